// File: rtl/stopwatch_pkg.sv
// Shared constants and FSM state encoding for the stopwatch controller.
package stopwatch_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-FF synchroniser -> hold-time debouncer -> one-clock press pulse.
module key_debounce #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic press_p
);

  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        level_q, level_d;
  logic        prev_q, prev_d;
  logic [15:0] cnt_q, cnt_d;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    s1_d    = key_n;
    s2_d    = s1_q;
    prev_d  = level_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_CYCLES - 16'd1) begin
      level_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Everything resets to "key released" so no spurious press follows reset.
  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_p = prev_q & ~level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/clear controller for the stopwatch counter chain.
// Optional lap/freeze display feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int                 CNT_W      = stopwatch_pkg::CNT_W,
  parameter logic [15:0]        DEB_CYCLES = 16'd50000,
  parameter logic [CNT_W-1:0]   MAX_COUNT  = CNT_W'(9999),
  parameter bit                 WRAP       = 1'b0
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             tick,
  input  logic             btn_start_n,
  input  logic             btn_clear_n,
  input  logic             btn_lap_n,
  input  logic [CNT_W-1:0] count_val,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic [CNT_W-1:0] disp_val,
  output logic [1:0]       state,
  output logic             lap_active
);
  import stopwatch_pkg::*;

  logic   start_p, clear_p;
  logic   terminal, run_term;
  state_e state_q, state_d;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .CLOCK_50(CLOCK_50), .reset(reset), .key_n(btn_start_n), .press_p(start_p)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
    .CLOCK_50(CLOCK_50), .reset(reset), .key_n(btn_clear_n), .press_p(clear_p)
  );

  // Out-of-range feedback is treated as already terminal.
  assign terminal = (count_val >= MAX_COUNT);
  assign run_term = (state_q == ST_RUN) & tick & terminal;

  always_comb begin
    state_d = state_q;
    if (clear_p) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (start_p) state_d = ST_RUN;
        ST_RUN: begin
          if (start_p)                 state_d = ST_PAUSE;
          else if (run_term && !WRAP)  state_d = ST_DONE;
        end
        ST_PAUSE: if (start_p) state_d = ST_RUN;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign state   = state_q;
  assign cnt_en  = (state_q == ST_RUN) & tick & ~terminal & ~clear_p;
  assign cnt_clr = clear_p | (WRAP & run_term);

`ifdef STOPWATCH_LAP_EN
  logic             lap_p;
  logic             lap_active_q, lap_active_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_lap (
    .CLOCK_50(CLOCK_50), .reset(reset), .key_n(btn_lap_n), .press_p(lap_p)
  );

  always_comb begin
    lap_active_d = lap_active_q;
    hold_d       = hold_q;
    if (clear_p) begin
      lap_active_d = 1'b0;
    end else if (lap_p && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
      lap_active_d = ~lap_active_q;
      if (!lap_active_q) hold_d = count_val;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      lap_active_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      lap_active_q <= lap_active_d;
      hold_q       <= hold_d;
    end
  end

  assign lap_active = lap_active_q;
  assign disp_val   = lap_active_q ? hold_q : count_val;
`else
  logic unused_lap;
  assign unused_lap = btn_lap_n;
  assign lap_active = 1'b0;
  assign disp_val   = count_val;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench: WRAP=0 and WRAP=1 instances share stimulus and are checked every cycle.
module tb_stopwatch_ctrl;

  localparam int DEB  = 4;
  localparam int MAXC = 20;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  st;
    logic        en;
    logic        clr;
    logic        lap;
    logic [15:0] disp;
  } obs_t;

  logic        clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic        bs = 1'b1, bc = 1'b1, bl = 1'b1;
  logic [15:0] cv = '0;
  logic [15:0] cv_next = '0;

  logic [1:0]  st_w[2];
  logic        en_w[2], clr_w[2], lap_w[2];
  logic [15:0] disp_w[2];

  int checks = 0, errors = 0, cyc = 0;
  obs_t q0[$], q1[$];

  // Reference model state (state uses the documented 2-bit encoding as plain ints)
  int          m_st[2];
  bit          m_lap[2];
  logic [15:0] m_hold[2];
  bit          kh[3][2];
  bit          lvl[3];
  int          run[3];
  bit          pr[3];

  always #5 clk = ~clk;

  for (genvar w = 0; w < 2; w++) begin : g_dut
    stopwatch_ctrl #(
      .CNT_W(16), .DEB_CYCLES(16'd4), .MAX_COUNT(16'd20), .WRAP(w == 1)
    ) u_dut (
      .CLOCK_50(clk), .reset(rst), .tick(tick),
      .btn_start_n(bs), .btn_clear_n(bc), .btn_lap_n(bl),
      .count_val(cv), .cnt_en(en_w[w]), .cnt_clr(clr_w[w]),
      .disp_val(disp_w[w]), .state(st_w[w]), .lap_active(lap_w[w])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic obs_t dut_obs(input int w);
    return '{st: st_w[w], en: en_w[w], clr: clr_w[w], lap: lap_w[w], disp: disp_w[w]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      kh[k][0] = 1'b1; kh[k][1] = 1'b1;
      lvl[k] = 1'b1; run[k] = 0; pr[k] = 1'b0;
    end
    for (int w = 0; w < 2; w++) begin
      m_st[w] = 0; m_lap[w] = 1'b0; m_hold[w] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One clock edge of the model; called just after the edge, before inputs change.
  task automatic model_edge();
    bit kn[3];
    bit fell[3];
    bit v, term;
    kn = '{bs, bc, bl};
    for (int k = 0; k < 3; k++) begin
      v = kh[k][1];              // key as it was two edges ago (synchroniser delay)
      kh[k][1] = kh[k][0];
      kh[k][0] = kn[k];
      fell[k] = 1'b0;
      if (v == lvl[k]) run[k] = 0;
      else begin
        run[k]++;
        if (run[k] == DEB) begin
          lvl[k] = v; run[k] = 0; fell[k] = (v == 1'b0);
        end
      end
    end
    term = (cv >= MAXC);
    for (int w = 0; w < 2; w++) begin
      if (pr[1]) begin
        m_st[w] = 0; m_lap[w] = 1'b0;
      end else begin
        if (LAP_EN && pr[2] && (m_st[w] == 1 || m_st[w] == 2)) begin
          if (!m_lap[w]) m_hold[w] = cv;
          m_lap[w] = !m_lap[w];
        end
        case (m_st[w])
          0: if (pr[0]) m_st[w] = 1;
          1: if (pr[0]) m_st[w] = 2;
             else if (tick && term) m_st[w] = (w == 1) ? 1 : 3;
          2: if (pr[0]) m_st[w] = 1;
          default: ;
        endcase
      end
    end
    pr = fell;
  endtask

  task automatic push_exp();
    obs_t e;
    bit term;
    term = (cv >= MAXC);
    for (int w = 0; w < 2; w++) begin
      e.st   = 2'(m_st[w]);
      e.en   = (m_st[w] == 1) && tick && !term && !pr[1];
      e.clr  = pr[1] || ((w == 1) && m_st[w] == 1 && tick && term);
      e.lap  = m_lap[w];
      e.disp = m_lap[w] ? m_hold[w] : cv;
      if (w == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic cycle(input bit s, input bit c, input bit l);
    @(posedge clk);
    #1;
    model_edge();
    cyc++;
    bs = s; bc = c; bl = l;
    tick = (cyc % 5 == 4);
    cv = cv_next;
    push_exp();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b1);
  endtask

  task automatic press(input int which, input int hold);
    for (int i = 0; i < hold; i++) cycle(which != 0, which != 1, which != 2);
    idle_cycles(8);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (q0.size() > 0) check($sformatf("w0_cyc%0d", cyc), dut_obs(0), q0.pop_front());
      if (q1.size() > 0) check($sformatf("w1_cyc%0d", cyc), dut_obs(1), q1.pop_front());
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) begin
      check($sformatf("rst_state_w%0d", w), 32'(st_w[w]), 32'd0);
      check($sformatf("rst_en_w%0d", w), 32'(en_w[w]), 32'd0);
      check($sformatf("rst_clr_w%0d", w), 32'(clr_w[w]), 32'd0);
      check($sformatf("rst_lap_w%0d", w), 32'(lap_w[w]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int seg[3];
    bit lv[3];

    // Power-on reset
    tick = 1'b1; cv = 16'd5;
    do_reset();
    tick = 1'b0; cv = '0;

    // 1: start key held 10 clocks; RUN appears after the 7th edge sampling it low
    cv_next = 16'd3;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      if (i == 7 || i == 8) begin
        @(negedge clk);
        check($sformatf("start_edge%0d", i - 1), 32'(st_w[0]), (i == 8) ? 32'd1 : 32'd0);
      end
    end
    idle_cycles(12);
    press(1, 6);

    // 2: bounce low2/high1/low2 must not register
    cycle(1'b0, 1'b1, 1'b1); cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1); cycle(1'b0, 1'b1, 1'b1);
    idle_cycles(10);
    @(negedge clk);
    check("bounce_idle", 32'(st_w[0]), 32'd0);

    // 3/4: terminal count with and without wrap, then start ignored in DONE, clear
    press(0, 6);
    cv_next = 16'd20;
    idle_cycles(12);
    @(negedge clk);
    check("done_w0", 32'(st_w[0]), 32'd3);
    check("wrap_w1", 32'(st_w[1]), 32'd1);
    press(0, 6);
    press(1, 6);

    // 6: lap freeze at count 7, release on second lap
    cv_next = 16'd7;
    press(0, 6);
    press(2, 6);
    for (int i = 8; i < 14; i++) begin cv_next = 16'(i); idle_cycles(2); end
    press(2, 6);
    cv_next = 16'd15;
    idle_cycles(4);

    // 5: start and clear pressed together in RUN
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1);
    idle_cycles(8);
    @(negedge clk);
    check("start_clear_idle", 32'(st_w[0]), 32'd0);

    // 5b: reset asserted mid-RUN while tick is high, checked with no clock edge
    cv_next = 16'd5;
    press(0, 6);
    do cycle(1'b1, 1'b1, 1'b1); while (!tick);
    #2;
    check("pre_rst_en", 32'(en_w[0]), 32'd1);
    do_reset();

    // Random key activity and feedback values
    for (int k = 0; k < 3; k++) begin seg[k] = 0; lv[k] = 1'b1; end
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++) begin
        if (seg[k] == 0) begin
          lv[k]  = (k == 1) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) != 0);
          seg[k] = $urandom_range(1, 12);
        end
        seg[k]--;
      end
      if ($urandom_range(0, 3) == 0) cv_next = 16'(MAXC - 1 + $urandom_range(0, 2));
      else                           cv_next = 16'($urandom_range(0, MAXC));
      cycle(lv[0], lv[1], lv[2]);
    end
    idle_cycles(2);
    @(negedge clk);
    #1;
    check("sb_drain", 32'(q0.size() + q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
